// File: rtl/mac_secuencial_pkg.sv
// -----------------------------------------------------------------------------
// mac_secuencial_pkg
// Shared definitions for the sequential multiply-accumulate block:
//   - state_t  : FSM state encoding (IDLE, CLEAR, ACUM, SCALE, DONE)
//   - SEL_ACUM / SEL_CLR : accumulator clear/pass mux select codes
//   - cnt_w()  : width of the beat counter for a given tap count
// -----------------------------------------------------------------------------
package mac_secuencial_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_ACUM  = 3'd2,
      ST_SCALE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] SEL_ACUM = 2'b00;
   localparam logic [1:0] SEL_CLR  = 2'b01;

   // The counter must be able to hold TAPS itself (value after the last beat).
   function automatic int cnt_w(input int taps);
      return $clog2(taps + 1);
   endfunction

endpackage

// File: rtl/mac_secuencial_if.sv
// -----------------------------------------------------------------------------
// mac_secuencial_if
// Request/response bundle of the MAC block.
//   master (requester) drives : start, in_valid, coef, dato
//   slave  (MAC)       drives : in_ready, sel_ac, acum, y, y_valid, busy
// -----------------------------------------------------------------------------
interface mac_secuencial_if #(
   parameter int N = 25
);
   logic                  start;
   logic                  in_valid;
   logic                  in_ready;
   logic signed [N-1:0]   coef;
   logic signed [N-1:0]   dato;
   logic [1:0]            sel_ac;
   logic signed [2*N-1:0] acum;
   logic signed [N-1:0]   y;
   logic                  y_valid;
   logic                  busy;

   modport master (
      output start, in_valid, coef, dato,
      input  in_ready, sel_ac, acum, y, y_valid, busy
   );

   modport slave (
      input  start, in_valid, coef, dato,
      output in_ready, sel_ac, acum, y, y_valid, busy
   );
endinterface

// File: rtl/sat_escala.sv
// -----------------------------------------------------------------------------
// sat_escala
// Combinational rescale of the 2N-bit accumulator to an N-bit result:
// arithmetic shift right by F (floor), then clamp to [-2^(N-1), 2^(N-1)-1].
//   i_acum : signed 2N-bit accumulator
//   o_y    : signed N-bit scaled and saturated value
// -----------------------------------------------------------------------------
module sat_escala #(
   parameter int N = 25,
   parameter int F = 12
) (
   input  logic signed [2*N-1:0] i_acum,
   output logic signed [N-1:0]   o_y
);

   // Limits expressed at 2N bits so the comparison is done on the full shifted value.
   localparam logic signed [2*N-1:0] LIM_MAX = {{(N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [2*N-1:0] LIM_MIN = {{(N+1){1'b1}}, {(N-1){1'b0}}};

   logic signed [2*N-1:0] w_sh;

   assign w_sh = i_acum >>> F;

   always_comb begin
      o_y = w_sh[N-1:0];
      if (w_sh > LIM_MAX) begin
         o_y = LIM_MAX[N-1:0];
      end else if (w_sh < LIM_MIN) begin
         o_y = LIM_MIN[N-1:0];
      end
   end

endmodule

// File: rtl/mac_secuencial.sv
// -----------------------------------------------------------------------------
// mac_secuencial
// Sequential MAC: after a start pulse, accumulates TAPS coef*dato products
// (full 2N-bit products, wrapping accumulator), then rescales the sum by F
// fraction bits with saturation and pulses y_valid for one cycle.
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : start / in_valid / coef / dato in,
//                  in_ready / sel_ac / acum / y / y_valid / busy out
// -----------------------------------------------------------------------------
module mac_secuencial
   import mac_secuencial_pkg::*;
#(
   parameter int N    = 25,
   parameter int F    = 12,
   parameter int TAPS = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   mac_secuencial_if.slave  bus
);

   localparam int CW = cnt_w(TAPS);

   state_t                r_state;
   state_t                w_next;
   logic [CW-1:0]         r_cnt;
   logic signed [2*N-1:0] r_acum;
   logic signed [N-1:0]   r_y;

   logic [1:0]            w_sel;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_last;
   logic signed [2*N-1:0] w_coef_x;
   logic signed [2*N-1:0] w_dato_x;
   logic signed [2*N-1:0] w_prod;
   logic signed [2*N-1:0] w_acum_mux;
   logic signed [N-1:0]   w_y_sat;

   // ---------------------------------------------------------------- control
   assign w_accept = w_in_ready && bus.in_valid;
   assign w_last   = (r_cnt == CW'(TAPS - 1));

   always_comb begin
      w_next     = r_state;
      w_sel      = SEL_CLR;
      w_in_ready = 1'b0;
      case (r_state)
         ST_IDLE:  if (bus.start) w_next = ST_CLEAR;
         ST_CLEAR: w_next = ST_ACUM;
         ST_ACUM: begin
            w_sel      = SEL_ACUM;
            w_in_ready = 1'b1;
            if (bus.in_valid && w_last) w_next = ST_SCALE;
         end
         ST_SCALE: w_next = ST_DONE;
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // --------------------------------------------------------------- datapath
   // Sign-extend both operands to 2N so the product is the exact signed result.
   assign w_coef_x = {{N{bus.coef[N-1]}}, bus.coef};
   assign w_dato_x = {{N{bus.dato[N-1]}}, bus.dato};
   assign w_prod   = w_coef_x * w_dato_x;

   // Clear/pass mux: clear forces zero, accumulate passes the running sum.
   assign w_acum_mux = (w_sel == SEL_CLR) ? '0 : (r_acum + w_prod);

   sat_escala #(.N(N), .F(F)) u_sat (
      .i_acum (r_acum),
      .o_y    (w_y_sat)
   );

   // acum only moves in CLEAR or on an accepted beat, so it holds through
   // stalls and after the result until the next computation clears it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_acum <= '0;
         r_cnt  <= '0;
         r_y    <= '0;
      end else begin
         if (r_state == ST_CLEAR) begin
            r_acum <= w_acum_mux;
            r_cnt  <= '0;
         end else if (w_accept) begin
            r_acum <= w_acum_mux;
            r_cnt  <= r_cnt + CW'(1);
         end
         if (r_state == ST_SCALE) r_y <= w_y_sat;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.in_ready = w_in_ready;
   assign bus.sel_ac   = w_sel;
   assign bus.acum     = r_acum;
   assign bus.y        = r_y;
   assign bus.y_valid  = (r_state == ST_DONE);
   assign bus.busy     = (r_state != ST_IDLE);

endmodule

// File: doc/mac_secuencial.md
MAC_SECUENCIAL -- requirements
Module: mac_secuencial

Interface
REQ-001 Parameter N, default 25, the sample/coefficient word width (signed, two's complement).
REQ-002 Parameter F, default 12, the number of fraction bits in coefficients and output.
REQ-003 Parameter TAPS, default 5, the number of products accumulated per output (legal range 2..63).
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle request to begin one output computation.
REQ-007 in_valid  input  1  coef/dato pair present.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 coef  input  N  signed coefficient.
REQ-010 dato  input  N  signed sample.
REQ-011 sel_ac  output  2  accumulator select code to the clear/pass mux: 2'b00 accumulate, 2'b01 clear.
REQ-012 acum  output  2N  signed running accumulator.
REQ-013 y  output  N  signed scaled and saturated result.
REQ-014 y_valid  output  1  one-cycle pulse when y is updated.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, ACUM, SCALE and DONE.
REQ-017 IDLE: in_ready=0, sel_ac=01; start=1 moves the FSM to CLEAR.
REQ-018 CLEAR (one cycle): acum<=0, the beat counter <=0, sel_ac=01, in_ready=0; then ACUM.
REQ-019 ACUM: in_ready=1 and sel_ac=00. A beat is accepted only when in_valid and in_ready are both 1; each accepted beat performs acum<=acum+coef*dato and increments the counter.
REQ-020 If in_valid=0 in ACUM, acum and the counter SHALL hold, with no limit on stall length.
REQ-021 Acceptance of beat TAPS moves the FSM to SCALE; in_ready SHALL be 0 outside ACUM.
REQ-022 The product SHALL be a full 2N-bit signed product; the accumulator SHALL wrap modulo 2^(2N) with no saturation.
REQ-023 SCALE (one cycle): y<=sat(acum>>>F), using an arithmetic shift (floor). The saturation limits are +2^(N-1)-1 and -2^(N-1).
REQ-024 DONE (one cycle): y_valid=1, then IDLE.
REQ-025 y SHALL hold its value until the next SCALE; acum SHALL hold until the next CLEAR.
REQ-026 Latency: with the last beat accepted at edge m, y_valid SHALL be high during the cycle after edge m+1.
REQ-027 start SHALL be ignored while busy=1; it is neither queued nor able to restart the computation.
REQ-028 start SHALL be sampled in IDLE only; a start in the DONE cycle is ignored.

Reset
REQ-029 When reset_n=0 at a rising edge, the block SHALL enter IDLE and set acum=0, y=0, counter=0, y_valid=0, in_ready=0, busy=0 and sel_ac=01.
REQ-030 Reset mid-computation SHALL discard the partial sum; no y_valid is produced for that computation.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding and the select constants SEL_ACUM=2'b00 and SEL_CLR=2'b01, reused by the clear/pass mux.
REQ-032 The shift-and-saturate logic SHALL be a separate combinational sub-module, sat_escala (parameters N, F; input 2N bits, output N bits).

Verification
REQ-033 Unity gain (N=25, F=12, TAPS=5): five beats with coef=4096, dato=4096 -> acum=83886080, y=20480, and y_valid pulses two cycles after the fifth accept.
REQ-034 Negative saturation: five beats with coef=-2^20, dato=2^20 -> acum=-5*2^40, y=-16777216. Positive saturation: coef=2^20, dato=2^20 -> y=16777215.
REQ-035 Stalls: in_valid deasserted for 3 cycles between beats 2 and 3, with the same data as REQ-033 -> identical y=20480; acum is held during the stall.
REQ-036 Mixed signs: coef={4096,-4096,8192,-8192,2048}, dato=4096 -> y=2048; a second run without reset confirms that CLEAR zeroed acum.
REQ-037 start pulsed in ACUM and in DONE -> ignored, exactly one y_valid per accepted start.
REQ-038 reset_n=0 after the third beat -> IDLE with all outputs at their reset values; a following start with five beats gives a correct result with no residue.
